// File: rtl/instr_fetch_if.sv
// Instruction fetch bus bundle: core-side request/flush, byte-wide ROM
// read handshake and the instruction valid/ready hand-off to the core.
interface instr_fetch_if #(
  parameter int unsigned AddrW = 8
) ();

  // Core request side
  logic [AddrW-1:0] fetch_addr;
  logic             fetch_req;
  logic             flush;
  logic             fetch_busy;

  // ROM read side
  logic [AddrW-1:0] rom_addr;
  logic             rom_rd;
  logic [7:0]       rom_data;
  logic             rom_ack;

  // Instruction hand-off to the core
  logic [7:0]       opcode1;
  logic [7:0]       opcode2;
  logic             instr_valid;
  logic             instr_ready;
  logic             fetch_err;

  // Fetch unit view
  modport master (
    input  fetch_addr,
    input  fetch_req,
    input  flush,
    input  rom_data,
    input  rom_ack,
    input  instr_ready,
    output fetch_busy,
    output rom_addr,
    output rom_rd,
    output opcode1,
    output opcode2,
    output instr_valid,
    output fetch_err
  );

  // Core + ROM environment view
  modport slave (
    output fetch_addr,
    output fetch_req,
    output flush,
    output rom_data,
    output rom_ack,
    output instr_ready,
    input  fetch_busy,
    input  rom_addr,
    input  rom_rd,
    input  opcode1,
    input  opcode2,
    input  instr_valid,
    input  fetch_err
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads a 2-byte instruction (even address A, then
// A+1) from a byte-wide ROM over rom_rd/rom_ack, holds it and offers it to the
// core with instr_valid/instr_ready. Per-byte ack timeout substitutes NOPs.
module instr_fetch #(
  parameter int unsigned AddrW   = 8,
  parameter int unsigned Timeout = 15,
  parameter logic [7:0]  NopOp   = 8'h00
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  instr_fetch_if.master bus_io
);

  // Counter must be able to hold Timeout-1; Timeout >= 1.
  localparam int unsigned CntW = (Timeout < 2) ? 1 : $clog2(Timeout);
  localparam logic [CntW-1:0] CntLast = CntW'(Timeout - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReqHi,
    StReqLo,
    StValid
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             rom_rd_q, rom_rd_d;
  logic [AddrW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]       op1_q, op1_d;
  logic [7:0]       op2_q, op2_d;
  logic             err_q, err_d;
  logic             start;

  // Next-state, ROM request and instruction register update
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rom_rd_d   = rom_rd_q;
    rom_addr_d = rom_addr_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    err_d      = err_q;
    start      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.fetch_req) begin
          start = 1'b1;
        end
      end
      StReqHi: begin
        if (bus_io.rom_ack) begin
          op1_d      = bus_io.rom_data;
          state_d    = StReqLo;
          cnt_d      = '0;
          rom_addr_d = {rom_addr_q[AddrW-1:1], 1'b1};
        end else if (cnt_q == CntLast) begin
          op1_d    = NopOp;
          op2_d    = NopOp;
          err_d    = 1'b1;
          rom_rd_d = 1'b0;
          state_d  = StValid;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StReqLo: begin
        if (bus_io.rom_ack) begin
          op2_d    = bus_io.rom_data;
          rom_rd_d = 1'b0;
          state_d  = StValid;
        end else if (cnt_q == CntLast) begin
          op1_d    = NopOp;
          op2_d    = NopOp;
          err_d    = 1'b1;
          rom_rd_d = 1'b0;
          state_d  = StValid;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StValid: begin
        // A new request is only taken together with the core consuming.
        if (bus_io.instr_ready) begin
          if (bus_io.fetch_req) begin
            start = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush discards whatever the state logic decided, including a same-cycle
    // ack; a concurrent request restarts regardless of instr_ready.
    if (bus_io.flush) begin
      state_d    = StIdle;
      cnt_d      = '0;
      rom_rd_d   = 1'b0;
      rom_addr_d = rom_addr_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      err_d      = err_q;
      start      = bus_io.fetch_req;
    end

    // Accepted request: even-align the address, odd requests are flagged.
    if (start) begin
      state_d    = StReqHi;
      cnt_d      = '0;
      rom_rd_d   = 1'b1;
      rom_addr_d = {bus_io.fetch_addr[AddrW-1:1], 1'b0};
      if (bus_io.fetch_addr[0]) begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rom_rd_q   <= 1'b0;
      rom_addr_q <= '0;
      op1_q      <= 8'h00;
      op2_q      <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rom_rd_q   <= rom_rd_d;
      rom_addr_q <= rom_addr_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      err_q      <= err_d;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    bus_io.fetch_busy  = (state_q == StReqHi) || (state_q == StReqLo);
    bus_io.instr_valid = (state_q == StValid);
    bus_io.rom_rd      = rom_rd_q;
    bus_io.rom_addr    = rom_addr_q;
    bus_io.opcode1     = op1_q;
    bus_io.opcode2     = op2_q;
    bus_io.fetch_err   = err_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// fetches with random ROM ack delays, checked against a transaction model.
module tb_instr_fetch;

  localparam int Timeout = 15;
  localparam logic [7:0] NopOp = 8'h00;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  instr_fetch_if #(.AddrW(8)) bus ();

  instr_fetch #(
    .AddrW  (8),
    .Timeout(Timeout),
    .NopOp  (NopOp)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus_io  (bus.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rom [256];

  // Transaction-level model state
  logic       in_valid;
  logic       err_m;
  logic [7:0] e1_m;
  logic [7:0] e2_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Move to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fetch_req   = 1'b0;
    bus.flush       = 1'b0;
    bus.rom_ack     = 1'b0;
    bus.instr_ready = 1'b0;
    bus.fetch_addr  = 8'($urandom);
    bus.rom_data    = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_rd", 32'(bus.rom_rd), 0);
    check_eq("rst_addr", 32'(bus.rom_addr), 0);
    check_eq("rst_op1", 32'(bus.opcode1), 0);
    check_eq("rst_op2", 32'(bus.opcode2), 0);
    check_eq("rst_valid", 32'(bus.instr_valid), 0);
    check_eq("rst_busy", 32'(bus.fetch_busy), 0);
    check_eq("rst_err", 32'(bus.fetch_err), 0);
    clear_inputs();
    tick();
    tick();
    reset_n  = 1'b1;
    err_m    = 1'b0;
    in_valid = 1'b0;
  endtask

  // Present a request that is accepted this cycle (state is idle or valid)
  task automatic start_req(input logic [7:0] a);
    bus.fetch_addr  = a;
    bus.fetch_req   = 1'b1;
    bus.instr_ready = 1'b1;
    if (a[0]) err_m = 1'b1;
    tick();
    bus.fetch_req   = 1'b0;
    bus.instr_ready = 1'b0;
    bus.fetch_addr  = 8'($urandom);
  endtask

  // ROM side of one byte read: ack after d waiting cycles, or never if d >= Timeout
  task automatic serve_byte(input logic [7:0] addr, input int d, input string tag,
                            output logic timed_out, output logic [7:0] data);
    data = NopOp;
    timed_out = (d >= Timeout);
    for (int k = 0; k < Timeout; k++) begin
      check_eq({tag, "_rd"}, 32'(bus.rom_rd), 1);
      check_eq({tag, "_addr"}, 32'(bus.rom_addr), 32'(addr));
      check_eq({tag, "_busy"}, 32'(bus.fetch_busy), 1);
      check_eq({tag, "_valid"}, 32'(bus.instr_valid), 0);
      if (k == d) begin
        bus.rom_ack  = 1'b1;
        bus.rom_data = rom[addr];
        data = rom[addr];
      end else begin
        bus.rom_data = 8'($urandom);
      end
      tick();
      bus.rom_ack = 1'b0;
      if (k == d) break;
    end
  endtask

  // Serve both bytes of a fetch already in its first request cycle, then check delivery
  task automatic finish_fetch(input logic [7:0] a, input int d1, input int d2);
    logic [7:0] ea, b1, b2;
    logic to1, to2;
    ea = {a[7:1], 1'b0};
    serve_byte(ea, d1, "hi", to1, b1);
    if (to1) begin
      e1_m = NopOp;
      e2_m = NopOp;
      err_m = 1'b1;
    end else begin
      serve_byte({a[7:1], 1'b1}, d2, "lo", to2, b2);
      if (to2) begin
        e1_m = NopOp;
        e2_m = NopOp;
        err_m = 1'b1;
      end else begin
        e1_m = b1;
        e2_m = b2;
      end
    end
    check_eq("dlv_valid", 32'(bus.instr_valid), 1);
    check_eq("dlv_op1", 32'(bus.opcode1), 32'(e1_m));
    check_eq("dlv_op2", 32'(bus.opcode2), 32'(e2_m));
    check_eq("dlv_err", 32'(bus.fetch_err), 32'(err_m));
    check_eq("dlv_rd", 32'(bus.rom_rd), 0);
    check_eq("dlv_busy", 32'(bus.fetch_busy), 0);
    in_valid = 1'b1;
  endtask

  // Hold the instruction un-consumed, optionally with a pending request
  task automatic stall_valid(input int n, input logic hold_req);
    for (int k = 0; k < n; k++) begin
      bus.instr_ready = 1'b0;
      bus.fetch_req   = hold_req;
      bus.fetch_addr  = 8'($urandom);
      bus.rom_ack     = 1'($urandom);
      tick();
      bus.rom_ack = 1'b0;
      check_eq("stall_valid", 32'(bus.instr_valid), 1);
      check_eq("stall_rd", 32'(bus.rom_rd), 0);
      check_eq("stall_op1", 32'(bus.opcode1), 32'(e1_m));
      check_eq("stall_op2", 32'(bus.opcode2), 32'(e2_m));
    end
    bus.fetch_req = 1'b0;
  endtask

  task automatic release_to_idle();
    bus.instr_ready = 1'b1;
    bus.fetch_req   = 1'b0;
    tick();
    bus.instr_ready = 1'b0;
    check_eq("rel_valid", 32'(bus.instr_valid), 0);
    check_eq("rel_rd", 32'(bus.rom_rd), 0);
    in_valid = 1'b0;
  endtask

  task automatic flush_valid();
    bus.flush     = 1'b1;
    bus.fetch_req = 1'b0;
    tick();
    bus.flush = 1'b0;
    check_eq("fl_valid", 32'(bus.instr_valid), 0);
    check_eq("fl_rd", 32'(bus.rom_rd), 0);
    in_valid = 1'b0;
  endtask

  // Idle cycles with spurious acks that must be ignored
  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      bus.rom_ack  = 1'($urandom);
      bus.rom_data = 8'($urandom);
      tick();
      bus.rom_ack = 1'b0;
      check_eq("idle_valid", 32'(bus.instr_valid), 0);
      check_eq("idle_busy", 32'(bus.fetch_busy), 0);
      check_eq("idle_rd", 32'(bus.rom_rd), 0);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 15));
    if (r == 0) return Timeout + int'($urandom_range(0, 3));
    if (r == 1) return Timeout - 1;
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic to;
    int r;

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h10] = 8'h1A;
    rom[8'h11] = 8'h55;
    clear_inputs();
    err_m = 1'b0;
    in_valid = 1'b0;
    e1_m = 8'h00;
    e2_m = 8'h00;

    apply_reset();
    idle_cycles(2);

    // Zero-wait ROM: valid three cycles after the request
    start_req(8'h10);
    finish_fetch(8'h10, 0, 0);
    check_eq("zw_op1_const", 32'(bus.opcode1), 32'h1A);
    check_eq("zw_op2_const", 32'(bus.opcode2), 32'h55);
    release_to_idle();

    // Four-cycle ack delay per byte
    start_req(8'h10);
    finish_fetch(8'h10, 4, 4);
    check_eq("dly_err", 32'(bus.fetch_err), 0);
    release_to_idle();

    // Last-chance ack on the final wait cycle still wins
    start_req(8'h12);
    finish_fetch(8'h12, Timeout - 1, Timeout - 1);
    check_eq("late_err", 32'(bus.fetch_err), 0);

    // Stall in valid with a held request, then back-to-back acceptance
    stall_valid(5, 1'b1);
    start_req(8'h22);
    finish_fetch(8'h22, 0, 2);
    release_to_idle();

    // Never ack: timeout after Timeout cycles in the first request state
    start_req(8'h30);
    finish_fetch(8'h30, 1000, 0);
    check_eq("to_op1_const", 32'(bus.opcode1), 32'(NopOp));
    check_eq("to_err_const", 32'(bus.fetch_err), 1);
    release_to_idle();
    apply_reset();

    // Flush + request during the second byte, with an ack in the same cycle
    start_req(8'h20);
    serve_byte(8'h20, 0, "fhi", to, b);
    check_eq("fl_lo_addr", 32'(bus.rom_addr), 32'h21);
    bus.flush      = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 8'h40;
    bus.rom_ack    = 1'b1;
    bus.rom_data   = rom[8'h21];
    tick();
    bus.flush     = 1'b0;
    bus.fetch_req = 1'b0;
    bus.rom_ack   = 1'b0;
    finish_fetch(8'h40, 0, 1);
    check_eq("fl_op1_src", 32'(bus.opcode1), 32'(rom[8'h40]));
    check_eq("fl_op2_src", 32'(bus.opcode2), 32'(rom[8'h41]));
    flush_valid();

    // Odd address, then asynchronous reset in the middle of the second byte
    start_req(8'hFF);
    serve_byte(8'hFE, 0, "odd_hi", to, b);
    check_eq("odd_lo_addr", 32'(bus.rom_addr), 32'hFF);
    check_eq("odd_lo_rd", 32'(bus.rom_rd), 1);
    check_eq("odd_err", 32'(bus.fetch_err), 1);
    apply_reset();

    // Random traffic
    for (int it = 0; it < 250; it++) begin
      if (!in_valid) idle_cycles(int'($urandom_range(0, 2)));
      if (in_valid && ($urandom_range(0, 1) == 1)) stall_valid(int'($urandom_range(1, 4)), 1'b1);
      a = 8'($urandom);
      start_req(a);
      finish_fetch(a, pick_delay(), pick_delay());
      r = int'($urandom_range(0, 7));
      if (r == 0) begin
        release_to_idle();
        apply_reset();
      end else if (r <= 2) begin
        release_to_idle();
      end else if (r == 3) begin
        flush_valid();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
